// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
// Holds the FSM state and instruction-class enums, opcode values, the 4-bit
// ALU operation encoding, PC-source and trap-cause codes, the control-vector
// payload struct and the opcode classifier used in DECODE.
package seq_pkg;

    localparam int unsigned OPC_W    = 7;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned F7_W     = 7;
    localparam int unsigned ALUOP_W  = 4;
    localparam int unsigned ALUSRC_W = 2;
    localparam int unsigned PCSEL_W  = 2;
    localparam int unsigned CAUSE_W  = 2;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_e;

    typedef enum logic [2:0] {
        IC_R, IC_I, IC_LOAD, IC_STORE, IC_BRANCH, IC_JAL, IC_JALR
    } iclass_e;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    localparam logic [ALUSRC_W-1:0] ALU_SRC_RS2 = 2'b00;
    localparam logic [ALUSRC_W-1:0] ALU_SRC_IMM = 2'b01;

    localparam logic [PCSEL_W-1:0] PC_PLUS4  = 2'b00;
    localparam logic [PCSEL_W-1:0] PC_BRANCH = 2'b01;
    localparam logic [PCSEL_W-1:0] PC_JAL    = 2'b10;
    localparam logic [PCSEL_W-1:0] PC_JALR   = 2'b11;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_BUS     = 2'b10;

    // Full control vector driven towards memory and datapath.
    typedef struct packed {
        logic                mem_req;
        logic                iord;
        logic                ir_write;
        logic                pc_write;
        logic [PCSEL_W-1:0]  pc_sel;
        logic [ALUSRC_W-1:0] alu_src;
        alu_op_e             alu_op;
        logic                branch;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
        logic                retire;
        logic                halted;
        logic [CAUSE_W-1:0]  trap_cause;
    } ctrl_t;

    typedef struct packed {
        logic    legal;
        iclass_e iclass;
    } decode_t;

    // Map an opcode to its instruction class; unknown opcodes are flagged illegal.
    function automatic decode_t classify(input logic [OPC_W-1:0] opcode);
        decode_t d;
        d.legal  = 1'b1;
        d.iclass = IC_R;
        case (opcode)
            OP_R:      d.iclass = IC_R;
            OP_I:      d.iclass = IC_I;
            OP_LOAD:   d.iclass = IC_LOAD;
            OP_STORE:  d.iclass = IC_STORE;
            OP_BRANCH: d.iclass = IC_BRANCH;
            OP_JAL:    d.iclass = IC_JAL;
            OP_JALR:   d.iclass = IC_JALR;
            default:   d.legal  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Bundle between the sequencer, instruction register, shared memory port
// and datapath.
//   master (sequencer): in  opcode/funct3/funct7/branch_taken/mem_ready
//                       out mem_req/iord/ir_write/pc_write/pc_sel, the
//                           datapath control vector, retire/halted/
//                           trap_cause/instret
//   slave  (datapath/memory side): the mirror image.
interface multicycle_sequencer_if
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic [OPC_W-1:0]    opcode;
    logic [F3_W-1:0]     funct3;
    logic [F7_W-1:0]     funct7;
    logic                branch_taken;
    logic                mem_ready;
    logic                mem_req;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic [PCSEL_W-1:0]  pc_sel;
    logic [ALUSRC_W-1:0] ALUSrc;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                Branch;
    logic                MemRead;
    logic                MemWrite;
    logic                MemToReg;
    logic                RegWrite;
    logic                retire;
    logic                halted;
    logic [CAUSE_W-1:0]  trap_cause;
    logic [CNT_W-1:0]    instret;

    modport master (
        input  opcode, funct3, funct7, branch_taken, mem_ready,
        output mem_req, iord, ir_write, pc_write, pc_sel,
               ALUSrc, ALUOp, Branch, MemRead, MemWrite, MemToReg, RegWrite,
               retire, halted, trap_cause, instret
    );

    modport slave (
        output opcode, funct3, funct7, branch_taken, mem_ready,
        input  mem_req, iord, ir_write, pc_write, pc_sel,
               ALUSrc, ALUOp, Branch, MemRead, MemWrite, MemToReg, RegWrite,
               retire, halted, trap_cause, instret
    );
endinterface

// File: rtl/seq_alu_decode.sv
// Combinational ALU control decode for the EXEC step.
//   iclass    in  latched instruction class
//   funct3    in  instr[14:12]
//   funct7    in  instr[31:25]
//   alu_op_c  out ALU operation
//   alu_src_c out ALU B-operand select (rs2 / immediate)
module seq_alu_decode
    import seq_pkg::*;
(
    input  iclass_e             iclass,
    input  logic [F3_W-1:0]     funct3,
    input  logic [F7_W-1:0]     funct7,
    output alu_op_e             alu_op_c,
    output logic [ALUSRC_W-1:0] alu_src_c
);

    // funct7 = 0100000 selects sub (R only) and sra/srai.
    logic alt;
    assign alt = (funct7 == 7'b0100000);

    always_comb begin
        alu_op_c  = ALU_ADD;
        alu_src_c = ALU_SRC_IMM;
        case (iclass)
            IC_R, IC_I: begin
                alu_src_c = (iclass == IC_R) ? ALU_SRC_RS2 : ALU_SRC_IMM;
                case (funct3)
                    3'b000:  alu_op_c = (iclass == IC_R && alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_c = ALU_SLL;
                    3'b010:  alu_op_c = ALU_SLT;
                    3'b011:  alu_op_c = ALU_SLTU;
                    3'b100:  alu_op_c = ALU_XOR;
                    3'b101:  alu_op_c = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_c = ALU_OR;
                    default: alu_op_c = ALU_AND;
                endcase
            end
            IC_BRANCH: begin
                alu_op_c  = ALU_SUB;
                alu_src_c = ALU_SRC_RS2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I datapath: FETCH/DECODE/EXEC/MEM/WB
// per instruction, one shared memory port via mem_req/mem_ready, sticky TRAP
// on illegal opcode or memory timeout.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  master side of multicycle_sequencer_if (instruction fields, memory
//        handshake, datapath control vector, retire/halted/trap_cause/instret)
// Parameters: MEM_TIMEOUT (0 disables the wait limit), CNT_W (instret width).
// Macro RETIRE_CNT_EN: when defined, instret counts retired instructions;
// otherwise instret is constant 0.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
)(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_sequencer_if.master bus
);

    localparam int unsigned TO_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam bit          TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e                 state_q, state_d;
    iclass_e                cls_q, cls_d;
    logic [CAUSE_W-1:0]     cause_q, cause_d;
    logic [TO_W-1:0]        wait_q, wait_d;

    alu_op_e                alu_op_c;
    logic [ALUSRC_W-1:0]    alu_src_c;
    decode_t                dec_c;
    logic                   timeout_c;
    ctrl_t                  ctrl_raw_c;
    ctrl_t                  ctrl_c;

    seq_alu_decode u_alu_decode (
        .iclass    (cls_q),
        .funct3    (bus.funct3),
        .funct7    (bus.funct7),
        .alu_op_c  (alu_op_c),
        .alu_src_c (alu_src_c)
    );

    assign dec_c = classify(bus.opcode);

    // Last permitted wait cycle with no ready; a ready on this cycle still wins.
    assign timeout_c = TO_EN && !bus.mem_ready && (wait_q == TO_LAST);

    // State, instruction class, trap cause and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            cls_q   <= IC_R;
            cause_q <= CAUSE_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
        end
    end

    // Next state and control-vector decode.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        cause_d    = cause_q;
        wait_d     = '0;
        ctrl_raw_c = '0;
        unique case (state_q)
            FETCH: begin
                ctrl_raw_c.mem_req  = 1'b1;
                ctrl_raw_c.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ctrl_raw_c.ir_write = 1'b1;
                    ctrl_raw_c.pc_write = 1'b1;
                    ctrl_raw_c.pc_sel   = PC_PLUS4;
                    state_d             = DECODE;
                end else if (timeout_c) begin
                    state_d = TRAP;
                    cause_d = CAUSE_BUS;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            DECODE: begin
                if (dec_c.legal) begin
                    cls_d   = dec_c.iclass;
                    state_d = EXEC;
                end else begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            EXEC: begin
                ctrl_raw_c.alu_op  = alu_op_c;
                ctrl_raw_c.alu_src = alu_src_c;
                case (cls_q)
                    IC_R, IC_I:         state_d = WB;
                    IC_LOAD, IC_STORE:  state_d = MEM;
                    IC_BRANCH: begin
                        ctrl_raw_c.branch   = 1'b1;
                        ctrl_raw_c.pc_write = bus.branch_taken;
                        ctrl_raw_c.pc_sel   = PC_BRANCH;
                        ctrl_raw_c.retire   = 1'b1;
                        state_d             = FETCH;
                    end
                    IC_JAL: begin
                        ctrl_raw_c.pc_write = 1'b1;
                        ctrl_raw_c.pc_sel   = PC_JAL;
                        state_d             = WB;
                    end
                    IC_JALR: begin
                        ctrl_raw_c.pc_write = 1'b1;
                        ctrl_raw_c.pc_sel   = PC_JALR;
                        state_d             = WB;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                ctrl_raw_c.mem_req   = 1'b1;
                ctrl_raw_c.iord      = 1'b1;
                ctrl_raw_c.mem_read  = (cls_q == IC_LOAD);
                ctrl_raw_c.mem_write = (cls_q == IC_STORE);
                if (bus.mem_ready) begin
                    if (cls_q == IC_STORE) begin
                        ctrl_raw_c.retire = 1'b1;
                        state_d           = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (timeout_c) begin
                    state_d = TRAP;
                    cause_d = CAUSE_BUS;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            WB: begin
                ctrl_raw_c.reg_write  = 1'b1;
                ctrl_raw_c.mem_to_reg = (cls_q == IC_LOAD);
                ctrl_raw_c.retire     = 1'b1;
                state_d               = FETCH;
            end
            TRAP: begin
                ctrl_raw_c.halted     = 1'b1;
                ctrl_raw_c.trap_cause = cause_q;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset forces every output low at once, so an in-flight access is dropped.
    assign ctrl_c = rst ? ctrl_t'('0) : ctrl_raw_c;

    assign bus.mem_req    = ctrl_c.mem_req;
    assign bus.iord       = ctrl_c.iord;
    assign bus.ir_write   = ctrl_c.ir_write;
    assign bus.pc_write   = ctrl_c.pc_write;
    assign bus.pc_sel     = ctrl_c.pc_sel;
    assign bus.ALUSrc     = ctrl_c.alu_src;
    assign bus.ALUOp      = ctrl_c.alu_op;
    assign bus.Branch     = ctrl_c.branch;
    assign bus.MemRead    = ctrl_c.mem_read;
    assign bus.MemWrite   = ctrl_c.mem_write;
    assign bus.MemToReg   = ctrl_c.mem_to_reg;
    assign bus.RegWrite   = ctrl_c.reg_write;
    assign bus.retire     = ctrl_c.retire;
    assign bus.halted     = ctrl_c.halted;
    assign bus.trap_cause = ctrl_c.trap_cause;

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] instret_q;

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (ctrl_raw_c.retire) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign bus.instret = instret_q;
`else
    assign bus.instret = CNT_W'(0);
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (MEM_TIMEOUT=4, CNT_W=4).
// Tasks drive one cycle at a time and push the expected output vector for
// that cycle; a negedge monitor pops and compares it.
module tb_multicycle_sequencer;

    logic clk;
    logic rst;

    multicycle_sequencer_if #(.CNT_W(4)) bus ();

    multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic [1:0] alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
        logic       halted;
        logic [1:0] trap_cause;
    } vec_t;

    typedef struct {
        string name;
        vec_t  v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   retired = 0;
    vec_t obs;

    assign obs = {bus.mem_req, bus.iord, bus.ir_write, bus.pc_write, bus.pc_sel,
                  bus.ALUSrc, bus.ALUOp, bus.Branch, bus.MemRead, bus.MemWrite,
                  bus.MemToReg, bus.RegWrite, bus.retire, bus.halted, bus.trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare each cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input string name, input vec_t v);
        exp_t e;
        e.name = name;
        e.v    = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_instret(input string name);
        logic [3:0] exp_cnt;
`ifdef RETIRE_CNT_EN
        exp_cnt = 4'(retired);
`else
        exp_cnt = 4'd0;
`endif
        n_tests++;
        if (bus.instret !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s_instret: got %0d expected %0d", name, bus.instret, exp_cnt);
        end
    endtask

    task automatic set_instr(input logic [31:0] instr, input bit taken);
        bus.opcode       = instr[6:0];
        bus.funct3       = instr[14:12];
        bus.funct7       = instr[31:25];
        bus.branch_taken = taken;
    endtask

    // Runs one instruction through the sequencer with the given fetch and
    // memory wait counts, queuing the expected vector for every cycle.
    task automatic exec_instr(input string name, input logic [31:0] instr,
                              input int fwait, input int mwait, input bit taken,
                              input logic [3:0] exp_op, input logic [1:0] exp_src);
        vec_t       v;
        logic [6:0] opc;
        bit         is_branch, is_load, is_store;
        opc       = instr[6:0];
        is_branch = (opc == 7'b1100011);
        is_load   = (opc == 7'b0000011);
        is_store  = (opc == 7'b0100011);
        set_instr(instr, taken);

        for (int i = 0; i < fwait; i++) begin
            bus.mem_ready = 1'b0;
            v = '0; v.mem_req = 1'b1; v.mem_read = 1'b1;
            step({name, "_fetch_wait"}, v);
        end
        bus.mem_ready = 1'b1;
        v = '0; v.mem_req = 1'b1; v.mem_read = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1;
        step({name, "_fetch"}, v);

        bus.mem_ready = 1'b0;
        v = '0;
        step({name, "_decode"}, v);

        v = '0; v.alu_op = exp_op; v.alu_src = exp_src;
        case (opc)
            7'b1100011: begin
                v.branch = 1'b1; v.pc_write = taken; v.pc_sel = 2'b01; v.retire = 1'b1;
            end
            7'b1101111: begin v.pc_write = 1'b1; v.pc_sel = 2'b10; end
            7'b1100111: begin v.pc_write = 1'b1; v.pc_sel = 2'b11; end
            default: ;
        endcase
        if (is_branch) retired++;
        step({name, "_exec"}, v);

        if (is_load || is_store) begin
            v = '0; v.mem_req = 1'b1; v.iord = 1'b1;
            v.mem_read = is_load; v.mem_write = is_store;
            for (int i = 0; i < mwait; i++) begin
                bus.mem_ready = 1'b0;
                step({name, "_mem_wait"}, v);
            end
            bus.mem_ready = 1'b1;
            v.retire = is_store;
            if (is_store) retired++;
            step({name, "_mem"}, v);
            bus.mem_ready = 1'b0;
        end

        if (!is_branch && !is_store) begin
            v = '0; v.reg_write = 1'b1; v.mem_to_reg = is_load; v.retire = 1'b1;
            retired++;
            step({name, "_wb"}, v);
        end
        check_instret(name);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        set_instr(32'h0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (obs !== vec_t'(0) || bus.instret !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_reset: got %b/%0d expected all zero", name, obs, bus.instret);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        retired = 0;
    endtask

    task automatic test_reset();
        do_reset("init");
    endtask

    task automatic test_alu();
        exec_instr("add",  32'h00B50533, 0, 0, 1'b0, 4'b0000, 2'b00);
        exec_instr("sub",  32'h40B50533, 0, 0, 1'b0, 4'b0001, 2'b00);
        exec_instr("sltu", 32'h00B53533, 2, 0, 1'b0, 4'b1001, 2'b00);
        exec_instr("addi", 32'h00150513, 0, 0, 1'b0, 4'b0000, 2'b01);
    endtask

    task automatic test_mem();
        exec_instr("lw", 32'h0005A503, 0, 3, 1'b0, 4'b0000, 2'b01);
        exec_instr("sw", 32'h00B52023, 0, 1, 1'b0, 4'b0000, 2'b01);
        exec_instr("sw_fast", 32'h00B52023, 0, 0, 1'b0, 4'b0000, 2'b01);
    endtask

    task automatic test_branch_jump();
        exec_instr("beq_t", 32'h00B50063, 0, 0, 1'b1, 4'b0001, 2'b00);
        exec_instr("beq_n", 32'h00B50063, 0, 0, 1'b0, 4'b0001, 2'b00);
        exec_instr("jal",   32'h000000EF, 0, 0, 1'b0, 4'b0000, 2'b01);
        exec_instr("jalr",  32'h000500E7, 0, 0, 1'b0, 4'b0000, 2'b01);
    endtask

    task automatic test_illegal();
        vec_t v;
        do_reset("illegal_pre");
        set_instr(32'h0000007F, 1'b0);
        bus.mem_ready = 1'b1;
        v = '0; v.mem_req = 1'b1; v.mem_read = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1;
        step("illegal_fetch", v);
        bus.mem_ready = 1'b0;
        v = '0;
        step("illegal_decode", v);
        v = '0; v.halted = 1'b1; v.trap_cause = 2'b01;
        for (int i = 0; i < 100; i++) begin
            bus.mem_ready = (i % 3 == 0);
            step("illegal_trap", v);
        end
        do_reset("illegal_clear");
    endtask

    task automatic test_timeout();
        vec_t v;
        do_reset("timeout_pre");
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b0;
            v = '0; v.mem_req = 1'b1; v.mem_read = 1'b1;
            step("timeout_fetch_wait", v);
        end
        v = '0; v.halted = 1'b1; v.trap_cause = 2'b10;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = (i >= 2);
            step("timeout_trap", v);
        end
        do_reset("timeout_clear");
        exec_instr("ready_on_4th", 32'h00150513, 3, 0, 1'b0, 4'b0000, 2'b01);
    endtask

    task automatic test_reset_mid_store();
        vec_t v;
        do_reset("midstore_pre");
        set_instr(32'h00B52023, 1'b0);
        bus.mem_ready = 1'b1;
        v = '0; v.mem_req = 1'b1; v.mem_read = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1;
        step("midstore_fetch", v);
        bus.mem_ready = 1'b0;
        v = '0;
        step("midstore_decode", v);
        v = '0; v.alu_src = 2'b01;
        step("midstore_exec", v);
        v = '0; v.mem_req = 1'b1; v.iord = 1'b1; v.mem_write = 1'b1;
        step("midstore_mem_wait", v);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== vec_t'(0) || bus.instret !== 4'd0) begin
            n_fail++;
            $display("FAIL midstore_async_reset: got %b/%0d expected all zero", obs, bus.instret);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        retired = 0;
        exec_instr("after_midstore", 32'h00150513, 0, 0, 1'b0, 4'b0000, 2'b01);
    endtask

    task automatic test_back_to_back();
        do_reset("b2b_pre");
        for (int i = 0; i < 17; i++) begin
            exec_instr("b2b_addi", 32'h00150513, 0, 0, 1'b0, 4'b0000, 2'b01);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        set_instr(32'h0, 1'b0);
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        test_back_to_back();
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
